retire_checker: RTL and testbench
=================================

RETIRE_CHECKER -- requirements
Module: retire_checker

Interface
REQ-001 Parameter XLEN, default 32, datapath width of the write-back data and the PC.
REQ-002 Parameter DEPTH, default 16, number of expected-result table entries (power of two); AW = log2(DEPTH).
REQ-003 Parameter TIMEOUT, default 1024, maximum number of RUN cycles before the check is abandoned.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  reset, asynchronous and active-low.
REQ-006 start  in  1  one-cycle pulse that begins a check run.
REQ-007 num_checks  in  AW+1  number of table entries to check, sampled on start.
REQ-008 exp_we, exp_addr[AW], exp_rd[5], exp_data[XLEN]  in  table write port, written only in IDLE or DONE.
REQ-009 wb_valid, wb_rd[5], wb_data[XLEN]  in  CPU register write-back event.
REQ-010 pc_valid, pc[XLEN]  in  CPU PC update event.
REQ-011 busy, done, pass, timeout, halted  out  1 each  status flags.
REQ-012 pass_count, fail_count  out  AW+1 each  compare results.
REQ-013 first_fail_idx  out  AW  index of the first mismatching entry.
REQ-014 cycle_count  out  32  RUN cycles elapsed.

Function
REQ-015 The FSM states SHALL be IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE on: all checks consumed, halt, or timeout.
- DONE->RUN on start.
- start in RUN: ignored.
REQ-016 On entering RUN, the block SHALL clear the following in the same edge:
- idx, pass_count, fail_count, cycle_count
- first_fail_idx, timeout, halted
REQ-017 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-018 In RUN, wb_valid with wb_rd!=0 SHALL be compared against table[idx].
- Match: rd==exp_rd and data==exp_data.
- Match increments pass_count; otherwise fail_count.
- idx increments after every compare.
- Counters are visible one cycle after the wb_valid cycle.
REQ-019 wb_valid with wb_rd==0 (NOP or x0 write) SHALL be ignored and SHALL NOT advance idx.
REQ-020 The first mismatch SHALL latch first_fail_idx; later mismatches SHALL NOT overwrite it.
REQ-021 When idx reaches num_checks, the block SHALL enter DONE on the same edge that performs the final compare.
REQ-022 num_checks==0 SHALL move RUN->DONE on the first RUN cycle with pass=1.
REQ-023 Halt detection:
- pc_valid with pc equal to the previously latched valid pc (self-loop such as jal x0,0) SHALL set halted and enter DONE.
- The latched pc SHALL be invalidated on entering RUN.
REQ-024 cycle_count SHALL increment every RUN cycle; when it reaches TIMEOUT-1 with no other exit, the block SHALL set timeout and enter DONE.
REQ-025 Simultaneous events: a compare SHALL be counted in the same cycle as a halt or timeout exit; priority for the exit cause SHALL be checks-complete > halted > timeout.
REQ-026 pass SHALL be 1 in DONE iff all of the following hold, and 0 otherwise:
- fail_count==0
- idx==num_checks
- timeout==0
REQ-027 In DONE and IDLE, wb_valid/pc_valid SHALL be ignored and all results SHALL hold stable.
REQ-028 exp_we in RUN SHALL be ignored; a table write is visible to the next run only.
REQ-029 Counters SHALL NOT wrap; pass_count + fail_count SHALL never exceed num_checks.

Reset
REQ-030 reset_n low SHALL asynchronously force:
- state to IDLE
- every output to 0
- latched-pc valid to 0
REQ-031 Reset mid-RUN SHALL abort the run with no done pulse; table contents are undefined after reset.

Structure
REQ-032 Package cpu_check_pkg SHALL hold the state enum and the default XLEN/DEPTH/TIMEOUT constants.
REQ-033 The expected table SHALL be a sub-module check_table (DEPTH x (5+XLEN), one synchronous write port, one combinational read port).

Verification
REQ-034 Table {x1=1, x2=3, x3=6}, num_checks=3, CPU writes these in order, interleaved with x0 NOP writes -> done, pass=1, pass_count=3, fail_count=0.
REQ-035 Same table, CPU writes x2=4 -> fail_count=1, first_fail_idx=1, pass=0.
REQ-036 num_checks=3, then pc 0x10 presented twice after two writes -> halted=1, done, pass=0, pass_count=2.
REQ-037 TIMEOUT=16, no wb_valid -> timeout=1 at cycle_count=15, pass=0.
REQ-038 Final compare and pc self-loop in the same cycle -> halted=0, pass=1; then start again -> counters cleared and busy=1.
REQ-039 reset_n pulsed low mid-RUN -> busy=0, done=0, all counts 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_check_pkg.sv
// Shared constants and FSM state type for the retirement checker.
package cpu_check_pkg;

  localparam int unsigned XLEN_DEFAULT    = 32;
  localparam int unsigned DEPTH_DEFAULT   = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/check_table.sv
// Expected-result table: one synchronous write port, one combinational read port.
module check_table #(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [4:0]      wrd_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [4:0]      rrd_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN+4:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= {wrd_i, wdata_i};
    end
  end

  assign {rrd_o, rdata_o} = mem_q[raddr_i];

endmodule

// File: rtl/retire_checker.sv
// Compares CPU register write-backs against a preloaded table of expected
// results, stopping on completion, a PC self-loop (halt) or a cycle timeout.
module retire_checker
  import cpu_check_pkg::*;
#(
  parameter  int unsigned XLEN    = XLEN_DEFAULT,
  parameter  int unsigned DEPTH   = DEPTH_DEFAULT,
  parameter  int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [AW:0]     num_checks,
  input  logic            exp_we,
  input  logic [AW-1:0]   exp_addr,
  input  logic [4:0]      exp_rd,
  input  logic [XLEN-1:0] exp_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            pc_valid,
  input  logic [XLEN-1:0] pc,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic            halted,
  output logic [AW:0]     pass_count,
  output logic [AW:0]     fail_count,
  output logic [AW-1:0]   first_fail_idx,
  output logic [31:0]     cycle_count
);

  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [31:0] CYC_LAST = 32'(TIMEOUT - 1);

  state_e          state_q;
  logic [AW:0]     num_q;
  logic [AW:0]     idx_q,  idx_d;
  logic [AW:0]     pcnt_q, pcnt_d;
  logic [AW:0]     fcnt_q, fcnt_d;
  logic [AW-1:0]   ffi_q;
  logic [31:0]     cyc_q,  cyc_d;
  logic [XLEN-1:0] pc_q;
  logic            pc_vld_q;
  logic            busy_q, done_q, pass_q, timeout_q, halted_q;

  logic [4:0]      tbl_rd;
  logic [XLEN-1:0] tbl_data;
  logic            tbl_we;
  logic            cmp_en, cmp_hit;
  logic            all_done, halt_hit, to_hit;

  // The table is frozen while a run is in progress.
  assign tbl_we = exp_we && (state_q != ST_RUN);

  check_table #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_table (
    .clk_i   (clk),
    .we_i    (tbl_we),
    .waddr_i (exp_addr),
    .wrd_i   (exp_rd),
    .wdata_i (exp_data),
    .raddr_i (idx_q[AW-1:0]),
    .rrd_o   (tbl_rd),
    .rdata_o (tbl_data)
  );

  always_comb begin
    cmp_en  = (state_q == ST_RUN) && wb_valid && (wb_rd != '0) && (idx_q < num_q);
    cmp_hit = (wb_rd == tbl_rd) && (wb_data == tbl_data);
    idx_d   = idx_q;
    pcnt_d  = pcnt_q;
    fcnt_d  = fcnt_q;
    if (cmp_en) begin
      idx_d = idx_q + CNT_ONE;
      if (cmp_hit) begin
        pcnt_d = pcnt_q + CNT_ONE;
      end else begin
        fcnt_d = fcnt_q + CNT_ONE;
      end
    end
    cyc_d    = cyc_q + 32'd1;
    // Exit decisions look at post-compare values so the final compare and
    // the DONE transition share one edge.
    all_done = (idx_d == num_q);
    halt_hit = pc_valid && pc_vld_q && (pc == pc_q);
    to_hit   = (cyc_d == CYC_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      num_q     <= '0;
      idx_q     <= '0;
      pcnt_q    <= '0;
      fcnt_q    <= '0;
      ffi_q     <= '0;
      cyc_q     <= '0;
      pc_q      <= '0;
      pc_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_RUN;
            num_q     <= num_checks;
            idx_q     <= '0;
            pcnt_q    <= '0;
            fcnt_q    <= '0;
            ffi_q     <= '0;
            cyc_q     <= '0;
            pc_vld_q  <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            halted_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          idx_q  <= idx_d;
          pcnt_q <= pcnt_d;
          fcnt_q <= fcnt_d;
          cyc_q  <= cyc_d;
          if (cmp_en && !cmp_hit && (fcnt_q == '0)) begin
            ffi_q <= idx_q[AW-1:0];
          end
          if (pc_valid) begin
            pc_q     <= pc;
            pc_vld_q <= 1'b1;
          end
          if (all_done || halt_hit || to_hit) begin
            state_q   <= ST_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            halted_q  <= !all_done && halt_hit;
            timeout_q <= !all_done && !halt_hit;
            pass_q    <= all_done && (fcnt_d == '0);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign halted         = halted_q;
  assign pass_count     = pcnt_q;
  assign fail_count     = fcnt_q;
  assign first_fail_idx = ffi_q;
  assign cycle_count    = cyc_q;

endmodule

// File: tb/tb_retire_checker.sv
// Directed and randomized checks of retire_checker against a cycle-list reference model.
module tb_retire_checker;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int TO    = 16;
  localparam int AW    = 3;

  logic            clk = 1'b0;
  logic            reset_n, start;
  logic [AW:0]     num_checks;
  logic            exp_we;
  logic [AW-1:0]   exp_addr;
  logic [4:0]      exp_rd;
  logic [XLEN-1:0] exp_data;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            pc_valid;
  logic [XLEN-1:0] pc;
  logic            busy, done, pass, timeout, halted;
  logic [AW:0]     pass_count, fail_count;
  logic [AW-1:0]   first_fail_idx;
  logic [31:0]     cycle_count;

  always #5 clk = ~clk;

  retire_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_checks(num_checks),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_rd(exp_rd), .exp_data(exp_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .pc_valid(pc_valid), .pc(pc),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .halted(halted),
    .pass_count(pass_count), .fail_count(fail_count),
    .first_fail_idx(first_fail_idx), .cycle_count(cycle_count)
  );

  int total = 0;
  int bad   = 0;

  logic [4:0]  t_rd   [DEPTH];
  logic [31:0] t_data [DEPTH];

  int          n_stim;
  logic        s_wbv  [32];
  logic [4:0]  s_rd   [32];
  logic [31:0] s_data [32];
  logic        s_pcv  [32];
  logic [31:0] s_pc   [32];

  logic        m_pass, m_to, m_halt;
  logic [3:0]  m_pcnt, m_fcnt;
  logic [2:0]  m_ffi;
  logic [31:0] m_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; exp_we = 0; exp_addr = '0; exp_rd = '0; exp_data = '0;
    wb_valid = 0; wb_rd = '0; wb_data = '0; pc_valid = 0; pc = '0; num_checks = '0;
  endtask

  task automatic write_entry(input int a, input logic [4:0] rd, input logic [31:0] d);
    exp_we = 1; exp_addr = 3'(a); exp_rd = rd; exp_data = d;
    tick();
    exp_we = 0;
    t_rd[a] = rd; t_data[a] = d;
  endtask

  task automatic push(input logic w, input logic [4:0] rd, input logic [31:0] d,
                      input logic p, input logic [31:0] pv);
    s_wbv[n_stim] = w; s_rd[n_stim] = rd; s_data[n_stim] = d;
    s_pcv[n_stim] = p; s_pc[n_stim] = pv;
    n_stim++;
  endtask

  task automatic do_start(input int num);
    start = 1; num_checks = 4'(num);
    tick();
    start = 0;
  endtask

  task automatic drive_run();
    for (int c = 0; c < 40; c++) begin
      if (done) break;
      if (c < n_stim) begin
        wb_valid = s_wbv[c]; wb_rd = s_rd[c]; wb_data = s_data[c];
        pc_valid = s_pcv[c]; pc = s_pc[c];
      end else begin
        wb_valid = 0; pc_valid = 0;
      end
      tick();
    end
    wb_valid = 0; pc_valid = 0;
  endtask

  // Replays the stimulus list one RUN cycle at a time using the stated rules.
  task automatic model_run(input int num);
    int          idx;
    int          c;
    bit          fin, pcok, hlt;
    logic [31:0] last;
    logic        w, p;
    logic [4:0]  rd;
    logic [31:0] d, pv;
    idx = 0; c = 0; fin = 0; pcok = 0; last = '0;
    m_pcnt = 0; m_fcnt = 0; m_ffi = 0; m_to = 0; m_halt = 0; m_cyc = 0;
    while (!fin) begin
      if (c < n_stim) begin
        w = s_wbv[c]; rd = s_rd[c]; d = s_data[c]; p = s_pcv[c]; pv = s_pc[c];
      end else begin
        w = 0; rd = 0; d = 0; p = 0; pv = 0;
      end
      m_cyc++;
      if (w && rd != 0 && idx < num) begin
        if (rd == t_rd[idx % DEPTH] && d == t_data[idx % DEPTH]) m_pcnt++;
        else begin
          if (m_fcnt == 0) m_ffi = 3'(idx);
          m_fcnt++;
        end
        idx++;
      end
      hlt = p && pcok && (pv == last);
      if (p) begin last = pv; pcok = 1; end
      if (idx == num) fin = 1;
      else if (hlt) begin m_halt = 1; fin = 1; end
      else if (m_cyc == 32'(TO - 1)) begin m_to = 1; fin = 1; end
      c++;
    end
    m_pass = (idx == num) && (m_fcnt == 0) && !m_to;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    #12;
    total++; if ({busy, done, pass, timeout, halted} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {busy, done, pass, timeout, halted}); end
    total++; if (pass_count !== 4'd0 || fail_count !== 4'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", pass_count, fail_count); end
    total++; if (cycle_count !== 32'd0 || first_fail_idx !== 3'd0) begin bad++; $display("FAIL reset_cyc_ffi got=%0d/%0d exp=0/0", cycle_count, first_fail_idx); end
    reset_n = 1;
    tick();
  endtask

  task automatic test_all_pass();
    logic [31:0] cyc_hold;
    write_entry(0, 5'd1, 32'd1);
    write_entry(1, 5'd2, 32'd3);
    write_entry(2, 5'd3, 32'd6);
    n_stim = 0;
    push(1, 5'd0, 32'hdead, 0, 0);
    push(1, 5'd1, 32'd1,    0, 0);
    push(1, 5'd0, 32'd0,    0, 0);
    push(1, 5'd2, 32'd3,    0, 0);
    push(0, 5'd2, 32'd9,    0, 0);
    push(1, 5'd3, 32'd6,    0, 0);
    model_run(3);
    do_start(3);
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL allpass_busy got=%b%b exp=10", busy, done); end
    drive_run();
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL allpass_done got=%b%b exp=10", done, busy); end
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL allpass_pass got=%0d exp=1", pass); end
    total++; if (pass_count !== 4'd3 || fail_count !== 4'd0) begin bad++; $display("FAIL allpass_counts got=%0d/%0d exp=3/0", pass_count, fail_count); end
    total++; if (cycle_count !== m_cyc) begin bad++; $display("FAIL allpass_cycles got=%0d exp=%0d", cycle_count, m_cyc); end
    cyc_hold = cycle_count;
    wb_valid = 1; wb_rd = 5'd1; wb_data = 32'd99; pc_valid = 1; pc = 32'h5;
    repeat (3) tick();
    wb_valid = 0; pc_valid = 0;
    total++; if (pass_count !== 4'd3 || fail_count !== 4'd0 || cycle_count !== cyc_hold || done !== 1'b1 || halted !== 1'b0) begin
      bad++; $display("FAIL done_hold got=%0d/%0d/%0d/%b exp=3/0/%0d/1", pass_count, fail_count, cycle_count, done, cyc_hold);
    end
  endtask

  task automatic test_mismatch();
    n_stim = 0;
    push(1, 5'd1, 32'd1, 0, 0);
    push(1, 5'd2, 32'd4, 0, 0);
    push(1, 5'd3, 32'd6, 0, 0);
    do_start(3);
    drive_run();
    total++; if (fail_count !== 4'd1 || pass_count !== 4'd2) begin bad++; $display("FAIL mismatch_counts got=%0d/%0d exp=2/1", pass_count, fail_count); end
    total++; if (first_fail_idx !== 3'd1) begin bad++; $display("FAIL mismatch_ffi got=%0d exp=1", first_fail_idx); end
    total++; if (pass !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL mismatch_pass got=%b%b exp=01", pass, done); end
    n_stim = 0;
    push(1, 5'd1, 32'd1, 0, 0);
    push(1, 5'd2, 32'd4, 0, 0);
    push(1, 5'd3, 32'd7, 0, 0);
    do_start(3);
    drive_run();
    total++; if (first_fail_idx !== 3'd1 || fail_count !== 4'd2) begin bad++; $display("FAIL ffi_sticky got=%0d/%0d exp=1/2", first_fail_idx, fail_count); end
  endtask

  task automatic test_halt();
    n_stim = 0;
    push(1, 5'd1, 32'd1, 0, 0);
    push(1, 5'd2, 32'd3, 0, 0);
    push(0, 5'd0, 32'd0, 1, 32'h10);
    push(0, 5'd0, 32'd0, 1, 32'h10);
    do_start(3);
    drive_run();
    total++; if (halted !== 1'b1 || done !== 1'b1 || timeout !== 1'b0) begin bad++; $display("FAIL halt_flags got=%b%b%b exp=110", halted, done, timeout); end
    total++; if (pass !== 1'b0 || pass_count !== 4'd2) begin bad++; $display("FAIL halt_result got=%0d/%0d exp=0/2", pass, pass_count); end
    total++; if (cycle_count !== 32'd4) begin bad++; $display("FAIL halt_cycles got=%0d exp=4", cycle_count); end
  endtask

  task automatic test_simultaneous();
    n_stim = 0;
    push(1, 5'd1, 32'd1, 1, 32'h10);
    push(1, 5'd2, 32'd3, 1, 32'h14);
    push(1, 5'd3, 32'd6, 1, 32'h14);
    do_start(3);
    drive_run();
    total++; if (halted !== 1'b0 || pass !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL simul_exit got=%b%b%b exp=011", halted, pass, done); end
    total++; if (pass_count !== 4'd3 || cycle_count !== 32'd3) begin bad++; $display("FAIL simul_counts got=%0d/%0d exp=3/3", pass_count, cycle_count); end
  endtask

  task automatic test_timeout();
    n_stim = 0;
    do_start(3);
    total++; if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0) begin bad++; $display("FAIL restart_flags got=%b%b%b exp=100", busy, done, pass); end
    total++; if (pass_count !== 4'd0 || fail_count !== 4'd0 || cycle_count !== 32'd0) begin bad++; $display("FAIL restart_clear got=%0d/%0d/%0d exp=0/0/0", pass_count, fail_count, cycle_count); end
    drive_run();
    total++; if (timeout !== 1'b1 || done !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL timeout_flags got=%b%b%b exp=110", timeout, done, halted); end
    total++; if (cycle_count !== 32'd15 || pass !== 1'b0) begin bad++; $display("FAIL timeout_cycles got=%0d/%0d exp=15/0", cycle_count, pass); end
  endtask

  task automatic test_zero_checks();
    n_stim = 0;
    do_start(0);
    drive_run();
    total++; if (done !== 1'b1 || pass !== 1'b1 || cycle_count !== 32'd1) begin bad++; $display("FAIL zero_checks got=%b%b/%0d exp=11/1", done, pass, cycle_count); end
  endtask

  task automatic test_write_in_run();
    write_entry(0, 5'd1, 32'd1);
    do_start(1);
    exp_we = 1; exp_addr = 3'd0; exp_rd = 5'd5; exp_data = 32'd77;
    wb_valid = 1; wb_rd = 5'd1; wb_data = 32'd1;
    tick();
    exp_we = 0; wb_valid = 0;
    total++; if (done !== 1'b1 || pass !== 1'b1 || pass_count !== 4'd1) begin bad++; $display("FAIL run_write_ignored got=%b%b/%0d exp=11/1", done, pass, pass_count); end
    n_stim = 0;
    push(1, 5'd1, 32'd1, 0, 0);
    do_start(1);
    drive_run();
    total++; if (pass !== 1'b1 || fail_count !== 4'd0) begin bad++; $display("FAIL run_write_next got=%0d/%0d exp=1/0", pass, fail_count); end
  endtask

  task automatic test_random();
    int          num, g, e;
    logic        w, p;
    logic [4:0]  rd;
    logic [31:0] d, pv;
    for (int it = 0; it < 30; it++) begin
      for (int a = 0; a < DEPTH; a++)
        write_entry(a, 5'($urandom_range(1, 31)), $urandom);
      num = $urandom_range(0, 7);
      n_stim = 0; g = 0;
      for (int k = 0; k < 14; k++) begin
        w  = ($urandom_range(0, 9) < 7);
        e  = g % DEPTH;
        rd = ($urandom_range(0, 4) == 0) ? 5'd0 : t_rd[e];
        d  = ($urandom_range(0, 3) == 0) ? $urandom : t_data[e];
        if (w && rd != 0) g++;
        p  = ($urandom_range(0, 4) == 0);
        pv = 32'h100 + 32'(4 * $urandom_range(0, 2));
        push(w, rd, d, p, pv);
      end
      model_run(num);
      do_start(num);
      drive_run();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL rnd%0d_done got=%0d exp=1", it, done); end
      total++; if (pass !== m_pass) begin bad++; $display("FAIL rnd%0d_pass got=%0d exp=%0d", it, pass, m_pass); end
      total++; if (pass_count !== m_pcnt || fail_count !== m_fcnt) begin bad++; $display("FAIL rnd%0d_counts got=%0d/%0d exp=%0d/%0d", it, pass_count, fail_count, m_pcnt, m_fcnt); end
      total++; if (first_fail_idx !== m_ffi) begin bad++; $display("FAIL rnd%0d_ffi got=%0d exp=%0d", it, first_fail_idx, m_ffi); end
      total++; if (timeout !== m_to || halted !== m_halt) begin bad++; $display("FAIL rnd%0d_exit got=%b%b exp=%b%b", it, timeout, halted, m_to, m_halt); end
      total++; if (cycle_count !== m_cyc) begin bad++; $display("FAIL rnd%0d_cycles got=%0d exp=%0d", it, cycle_count, m_cyc); end
    end
  endtask

  task automatic test_reset_midrun();
    write_entry(0, 5'd1, 32'd1);
    do_start(3);
    wb_valid = 1; wb_rd = 5'd1; wb_data = 32'd1;
    tick();
    wb_valid = 0;
    total++; if (busy !== 1'b1 || pass_count !== 4'd1) begin bad++; $display("FAIL midrun_pre got=%b/%0d exp=1/1", busy, pass_count); end
    #1;
    reset_n = 0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midrun_flags got=%b%b exp=00", busy, done); end
    total++; if (pass_count !== 4'd0 || fail_count !== 4'd0 || cycle_count !== 32'd0) begin bad++; $display("FAIL midrun_counts got=%0d/%0d/%0d exp=0/0/0", pass_count, fail_count, cycle_count); end
    #3;
    reset_n = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_mismatch();
    test_halt();
    test_simultaneous();
    test_timeout();
    test_zero_checks();
    test_write_in_run();
    test_random();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
